blink_scheduler: RTL and testbench
==================================

BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 SHALL have parameter ON_TICKS, default 3, number of blinkClock cycles the cursor digit is visible per blink period (legal 1..255).
REQ-002 SHALL have parameter OFF_TICKS, default 2, number of blinkClock cycles the cursor digit is hidden per blink period (legal 1..255).
REQ-003 SHALL have parameter HOLD_TICKS, default 4, number of cycles of forced visibility after a key or cursor move (legal 1..255).
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 20, number of inactive cycles before editing auto-exits; 0 disables the timeout (legal 0..255).
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port blinkClock, input, 1, clock: all state updates on its rising edge.
REQ-007 SHALL have port edit_active, input, 1, level: 1 while the user is editing a digit.
REQ-008 SHALL have port cursor_index, input, 2, index of the digit being edited.
REQ-009 SHALL have port key_toggle, input, 1, toggles once per keypress from a faster clock domain.
REQ-010 SHALL have port refresh_ack, input, 1, LCD refresh logic has consumed the current request.
REQ-011 SHALL have port blink, output, 1, 1 means the cursor digit is visible, 0 means it is hidden.
REQ-012 SHALL have port blink_index, output, 2, registered cursor digit index.
REQ-013 SHALL have port refresh_req, output, 1, display content changed and a refresh is needed.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse when editing auto-exits.

Function
REQ-015 SHALL pass key_toggle through two synchronising flops plus one history flop; key_evt = stage2 XOR stage3, exactly one cycle per toggle, 3-cycle latency.
REQ-016 SHALL implement states IDLE, SHOW, HIDE, HOLD; blink=0 only in HIDE, blink=1 in IDLE, SHOW and HOLD, registered.
REQ-017 SHALL move IDLE->SHOW with cnt=0 when edit_active=1.
REQ-018 SHALL, in SHOW, increment cnt and, at cnt==ON_TICKS-1, move to HIDE with cnt=0.
REQ-019 SHALL, in HIDE, increment cnt and, at cnt==OFF_TICKS-1, move to SHOW with cnt=0.
REQ-020 SHALL treat key_evt, or cursor_index differing from blink_index, as activity: in SHOW/HIDE/HOLD go to HOLD with cnt=0; a further activity event in HOLD restarts cnt.
REQ-021 SHALL, in HOLD, move to SHOW with cnt=0 at cnt==HOLD_TICKS-1.
REQ-022 SHALL, in any non-IDLE state, count idle_cnt each cycle without activity and clear it on activity; at idle_cnt==TIMEOUT_TICKS-1 (TIMEOUT_TICKS!=0) go to IDLE and pulse timeout for one cycle.
REQ-023 SHALL apply the priority edit_active=0 (to IDLE, no timeout pulse) > timeout > activity > counter expiry when several events occur in one cycle.
REQ-024 SHALL load blink_index from cursor_index every cycle, in every state.
REQ-025 SHALL set refresh_req the cycle after blink or blink_index changes value, hold it until refresh_ack=1 is sampled, and keep it high if a new change coincides with the ack; refresh_ack while refresh_req=0 SHALL be ignored.
REQ-026 SHALL use 8-bit cnt and idle_cnt that never wrap; illegal parameter values SHALL be flagged by a simulation-time check.

Reset
REQ-027 SHALL, on rst, asynchronously force state=IDLE, blink=1, blink_index=0, cnt=0, idle_cnt=0, refresh_req=0, timeout=0 and all sync flops=0; rst mid-period or mid-handshake drops the pending request.
REQ-028 SHALL resume in IDLE on the first blinkClock edge after rst deasserts, and SHALL NOT report key_evt for that first edge.

Structure
REQ-029 SHALL take the state encodings (IDLE=0, SHOW=1, HOLD=2, HIDE=3) and the counter width from the shared defines header.
REQ-030 SHALL place the 3-flop synchroniser and edge detector in one sub-module, toggle_sync.

Verification
REQ-031 SHALL cover: edit_active=1 held, no keys -> blink pattern 1,1,1,0,0 repeating, with refresh_req raised at each edge of blink.
REQ-032 SHALL cover: key toggle while in HIDE -> blink=1 three cycles later, held for 4 cycles (HOLD), then SHOW.
REQ-033 SHALL cover: cursor_index 0->2 during SHOW -> blink_index=2 next cycle, HOLD entered, refresh_req=1 until ack.
REQ-034 SHALL cover: 20 cycles with no activity -> timeout pulse exactly once, state IDLE, blink=1.
REQ-035 SHALL cover: a blink change in the same cycle as refresh_ack -> refresh_req stays 1, and clears after the next ack.
REQ-036 SHALL cover: rst asserted mid-HIDE with refresh_req=1 -> immediately blink=1, refresh_req=0, state IDLE.

Source files
------------

// File: rtl/blink_scheduler_pkg.sv
// Shared definitions for the cursor blink scheduler: state encodings,
// counter width and a saturating increment helper.
package blink_scheduler_pkg;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2,
    HIDE = 2'd3
  } state_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : cnt_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/blink_scheduler_toggle_sync.sv
// Brings the keypress toggle into the blink clock domain and turns each
// toggle into a single-cycle event.
module toggle_sync (
  input  logic blinkClock,
  input  logic rst,
  input  logic key_toggle,
  output logic key_evt
);

  logic stage1;
  logic stage2;
  logic stage3;

  always_ff @(posedge blinkClock or posedge rst) begin
    if (rst) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
      stage3 <= 1'b0;
    end else begin
      stage1 <= key_toggle;
      stage2 <= stage1;
      stage3 <= stage2;
    end
  end

  assign key_evt = stage2 ^ stage3;

endmodule

// File: rtl/blink_scheduler.sv
// Cursor blink scheduler: blinks the edited digit, forces it visible after
// activity, auto-exits editing after inactivity and requests LCD refreshes.
//
//  state | meaning
//  IDLE  | not editing, digit shown steadily
//  SHOW  | blink phase, digit visible
//  HIDE  | blink phase, digit hidden
//  HOLD  | forced visible after a key or cursor move
module blink_scheduler
  import blink_scheduler_pkg::*;
#(
  parameter int ON_TICKS      = 3,
  parameter int OFF_TICKS     = 2,
  parameter int HOLD_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic       rst,
  input  logic       blinkClock,
  input  logic       edit_active,
  input  logic [1:0] cursor_index,
  input  logic       key_toggle,
  input  logic       refresh_ack,
  output logic       blink,
  output logic [1:0] blink_index,
  output logic       refresh_req,
  output logic       timeout
);

  localparam bit PARAMS_OK =
    (ON_TICKS >= 1) && (ON_TICKS <= 255) &&
    (OFF_TICKS >= 1) && (OFF_TICKS <= 255) &&
    (HOLD_TICKS >= 1) && (HOLD_TICKS <= 255) &&
    (TIMEOUT_TICKS >= 0) && (TIMEOUT_TICKS <= 255);

  if (!PARAMS_OK) begin : g_param_check
    $error("blink_scheduler: tick parameter outside its legal range");
  end

  localparam cnt_t ON_LAST   = cnt_t'(ON_TICKS - 1);
  localparam cnt_t OFF_LAST  = cnt_t'(OFF_TICKS - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_TICKS - 1);
  localparam cnt_t TO_LAST   = (TIMEOUT_TICKS == 0) ? '0 : cnt_t'(TIMEOUT_TICKS - 1);

  state_t     state;
  cnt_t       cnt;
  cnt_t       idle_cnt;
  logic       blink_d;
  logic [1:0] index_d;
  logic       key_evt;
  logic       activity;
  logic       timeout_hit;
  logic       changed;

  toggle_sync u_toggle_sync (
    .blinkClock (blinkClock),
    .rst        (rst),
    .key_toggle (key_toggle),
    .key_evt    (key_evt)
  );

  assign activity    = key_evt || (cursor_index != blink_index);
  assign timeout_hit = (TIMEOUT_TICKS != 0) && (idle_cnt == TO_LAST);
  // Compare against one-cycle-old copies so the request rises the cycle after a change.
  assign changed     = (blink != blink_d) || (blink_index != index_d);

  always_ff @(posedge blinkClock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      blink       <= 1'b1;
      blink_index <= 2'd0;
      cnt         <= '0;
      idle_cnt    <= '0;
      blink_d     <= 1'b1;
      index_d     <= 2'd0;
      refresh_req <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      blink_index <= cursor_index;
      blink_d     <= blink;
      index_d     <= blink_index;
      refresh_req <= changed || (refresh_req && !refresh_ack);
      timeout     <= 1'b0;

      if (!edit_active) begin
        state    <= IDLE;
        blink    <= 1'b1;
        cnt      <= '0;
        idle_cnt <= '0;
      end else if (state == IDLE) begin
        state    <= SHOW;
        blink    <= 1'b1;
        cnt      <= '0;
        idle_cnt <= '0;
      end else if (timeout_hit) begin
        state    <= IDLE;
        blink    <= 1'b1;
        cnt      <= '0;
        idle_cnt <= '0;
        timeout  <= 1'b1;
      end else if (activity) begin
        state    <= HOLD;
        blink    <= 1'b1;
        cnt      <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= sat_inc(idle_cnt);
        case (state)
          SHOW: begin
            if (cnt == ON_LAST) begin
              state <= HIDE;
              blink <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          HIDE: begin
            if (cnt == OFF_LAST) begin
              state <= SHOW;
              blink <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              state <= SHOW;
              blink <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: begin
            state <= IDLE;
            blink <= 1'b1;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler with default parameters; expected
// values are hand-derived cycle tables.
module tb_blink_scheduler;

  logic       rst;
  logic       blinkClock;
  logic       edit_active;
  logic [1:0] cursor_index;
  logic       key_toggle;
  logic       refresh_ack;
  logic       blink;
  logic [1:0] blink_index;
  logic       refresh_req;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  bit exp_b1 [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  bit exp_r1 [10] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1};
  bit exp_b2 [12] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  bit exp_b3 [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit exp_r3 [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  logic [1:0] exp_i3 [10] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  bit exp_b4 [5]  = '{1, 1, 1, 1, 0};
  bit exp_r5 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1};

  blink_scheduler dut (
    .rst          (rst),
    .blinkClock   (blinkClock),
    .edit_active  (edit_active),
    .cursor_index (cursor_index),
    .key_toggle   (key_toggle),
    .refresh_ack  (refresh_ack),
    .blink        (blink),
    .blink_index  (blink_index),
    .refresh_req  (refresh_req),
    .timeout      (timeout)
  );

  initial blinkClock = 1'b0;
  always #5 blinkClock = ~blinkClock;

  task automatic tick();
    @(posedge blinkClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    edit_active  = 1'b0;
    key_toggle   = 1'b0;
    cursor_index = 2'd0;
    refresh_ack  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    edit_active  = 1'b0;
    key_toggle   = 1'b0;
    cursor_index = 2'd0;
    refresh_ack  = 1'b0;
    #2;
    chk("rst_blink", blink, 1);
    chk("rst_index", blink_index, 0);
    chk("rst_req", refresh_req, 0);
    chk("rst_timeout", timeout, 0);
    tick();
    tick();
    rst = 1'b0;

    // Free-running blink with every refresh acknowledged at once.
    edit_active = 1'b1;
    refresh_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("blink_pattern_%0d", i), blink, exp_b1[i]);
      chk($sformatf("blink_req_%0d", i), refresh_req, exp_r1[i]);
    end

    // Keypress landing while the digit is hidden.
    do_reset();
    edit_active = 1'b1;
    refresh_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("key_hold_blink_%0d", i), blink, exp_b2[i]);
      if (i == 1) key_toggle = 1'b1;
    end

    // Cursor move during SHOW, request held until acknowledged.
    do_reset();
    edit_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("cursor_index_%0d", i), blink_index, exp_i3[i]);
      chk($sformatf("cursor_blink_%0d", i), blink, exp_b3[i]);
      chk($sformatf("cursor_req_%0d", i), refresh_req, exp_r3[i]);
      if (i == 1) cursor_index = 2'd2;
      if (i == 5) refresh_ack = 1'b1;
      if (i == 6) refresh_ack = 1'b0;
    end

    // Inactivity timeout: one pulse, then re-entry through IDLE.
    do_reset();
    edit_active = 1'b1;
    refresh_ack = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (timeout) pulses++;
      chk($sformatf("timeout_%0d", i), timeout, (i == 20) ? 8'd1 : 8'd0);
      if (i >= 20) chk($sformatf("timeout_blink_%0d", i), blink, exp_b4[i-20]);
    end
    chk("timeout_pulse_count", pulses[7:0], 1);

    // Blink change coinciding with an acknowledge keeps the request alive.
    do_reset();
    edit_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("ack_race_req_%0d", i), refresh_req, exp_r5[i]);
      if (i == 5 || i == 7) refresh_ack = 1'b1;
      if (i == 6 || i == 8) refresh_ack = 1'b0;
    end

    // Reset asserted mid-HIDE with a pending request.
    chk("pre_rst_blink", blink, 0);
    chk("pre_rst_req", refresh_req, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_blink", blink, 1);
    chk("async_rst_req", refresh_req, 0);
    chk("async_rst_timeout", timeout, 0);
    chk("async_rst_index", blink_index, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("resume_blink_e1", blink, 1);
    tick();
    tick();
    tick();
    chk("resume_blink_e4", blink, 0);
    chk("resume_req_e4", refresh_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
